// File: rtl/mips_control_fsm_pkg.sv
// ============================================================================
// Module      : mips_control_fsm_pkg
// Description : Shared opcodes, state encodings and datapath select codes for
//               the multicycle MIPS main control unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_control_fsm_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EX   = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    localparam logic [1:0] ULA_ADD   = 2'b00;
    localparam logic [1:0] ULA_SUB   = 2'b01;
    localparam logic [1:0] ULA_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ULA    = 2'b00;
    localparam logic [1:0] PCSRC_ULAOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mips_control_decode.sv
// ============================================================================
// Module      : mips_control_decode
// Description : Combinational state-to-control decoder for the multicycle
//               MIPS main control unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_control_decode
    import mips_control_fsm_pkg::*;
(
    input  state_t     i_state,
    input  logic       i_mem_ready,
    input  logic       i_op_legal,
    input  logic       i_rst_n,
    output logic       o_pc_write,
    output logic       o_branch,
    output logic       o_i_or_d,
    output logic       o_mem_read,
    output logic       o_mem_write,
    output logic       o_ir_write,
    output logic       o_mem_to_reg,
    output logic       o_reg_dst,
    output logic       o_reg_write,
    output logic       o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_ula_operation,
    output logic [1:0] o_pc_source,
    output logic       o_instr_done,
    output logic       o_illegal_op
);

    logic w_pc_write;
    logic w_ir_write;
    logic w_reg_write;
    logic w_mem_write;

    always_comb begin
        w_pc_write      = 1'b0;
        w_ir_write      = 1'b0;
        w_reg_write     = 1'b0;
        w_mem_write     = 1'b0;
        o_branch        = 1'b0;
        o_i_or_d        = 1'b0;
        o_mem_read      = 1'b0;
        o_mem_to_reg    = 1'b0;
        o_reg_dst       = 1'b0;
        o_alu_src_a     = 1'b0;
        o_alu_src_b     = SRCB_REG;
        o_ula_operation = ULA_ADD;
        o_pc_source     = PCSRC_ULA;
        o_instr_done    = 1'b0;
        o_illegal_op    = 1'b0;
        case (i_state)
            S_FETCH: begin
                o_mem_read  = 1'b1;
                o_alu_src_b = SRCB_FOUR;
                w_ir_write  = i_mem_ready;
                w_pc_write  = i_mem_ready;
            end
            S_DECODE: begin
                o_alu_src_b  = SRCB_IMM_SH2;
                o_illegal_op = ~i_op_legal;
            end
            S_MEM_ADDR: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = SRCB_IMM;
            end
            S_MEM_READ: begin
                o_mem_read = 1'b1;
                o_i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                w_reg_write  = 1'b1;
                o_mem_to_reg = 1'b1;
                o_instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                w_mem_write  = 1'b1;
                o_i_or_d     = 1'b1;
                o_instr_done = i_mem_ready;
            end
            S_EXECUTE: begin
                o_alu_src_a     = 1'b1;
                o_ula_operation = ULA_FUNCT;
            end
            S_R_WB: begin
                w_reg_write  = 1'b1;
                o_reg_dst    = 1'b1;
                o_instr_done = 1'b1;
            end
            S_BRANCH: begin
                o_alu_src_a     = 1'b1;
                o_ula_operation = ULA_SUB;
                o_branch        = 1'b1;
                o_pc_source     = PCSRC_ULAOUT;
                o_instr_done    = 1'b1;
            end
            S_JUMP: begin
                w_pc_write   = 1'b1;
                o_pc_source  = PCSRC_JUMP;
                o_instr_done = 1'b1;
            end
            S_ADDI_EX: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = SRCB_IMM;
            end
            S_ADDI_WB: begin
                w_reg_write  = 1'b1;
                o_instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset is asynchronous, so the enables are masked combinationally too
    assign o_pc_write  = w_pc_write  & i_rst_n;
    assign o_ir_write  = w_ir_write  & i_rst_n;
    assign o_reg_write = w_reg_write & i_rst_n;
    assign o_mem_write = w_mem_write & i_rst_n;

endmodule

`default_nettype wire

// File: rtl/mips_control_fsm.sv
// ============================================================================
// Module      : mips_control_fsm
// Description : Multicycle MIPS main control unit: state register, next-state
//               logic and memory-ready stalling.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_control_fsm
    import mips_control_fsm_pkg::*;
#(
    parameter int MEM_WAIT_EN = 1,
    parameter int STATE_W     = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               branch,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         ula_operation,
    output logic [1:0]         pc_source,
    output logic               instr_done,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    state_t r_state;
    state_t w_next_state;
    logic   w_mem_ready;

    assign w_mem_ready = mem_ready | (MEM_WAIT_EN == 0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH:     w_next_state = w_mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_next_state = S_MEM_ADDR;
                    OP_RTYPE:     w_next_state = S_EXECUTE;
                    OP_BEQ:       w_next_state = S_BRANCH;
                    OP_J:         w_next_state = S_JUMP;
                    OP_ADDI:      w_next_state = S_ADDI_EX;
                    default:      w_next_state = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  w_next_state = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  w_next_state = w_mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: w_next_state = w_mem_ready ? S_FETCH : S_MEM_WRITE;
            S_EXECUTE:   w_next_state = S_R_WB;
            S_ADDI_EX:   w_next_state = S_ADDI_WB;
            default:     w_next_state = S_FETCH;
        endcase
    end

    mips_control_decode u_decode (
        .i_state         (r_state),
        .i_mem_ready     (w_mem_ready),
        .i_op_legal      (is_legal_op(opcode)),
        .i_rst_n         (reset),
        .o_pc_write      (pc_write),
        .o_branch        (branch),
        .o_i_or_d        (i_or_d),
        .o_mem_read      (mem_read),
        .o_mem_write     (mem_write),
        .o_ir_write      (ir_write),
        .o_mem_to_reg    (mem_to_reg),
        .o_reg_dst       (reg_dst),
        .o_reg_write     (reg_write),
        .o_alu_src_a     (alu_src_a),
        .o_alu_src_b     (alu_src_b),
        .o_ula_operation (ula_operation),
        .o_pc_source     (pc_source),
        .o_instr_done    (instr_done),
        .o_illegal_op    (illegal_op)
    );

    assign state = STATE_W'(r_state);

endmodule

`default_nettype wire

// File: tb/tb_mips_control_fsm.sv
// ============================================================================
// Module      : tb_mips_control_fsm
// Description : Directed vector bench for mips_control_fsm, with and without
//               memory wait states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_control_fsm;

    // {pc_write, branch, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
    //  reg_dst, reg_write, alu_src_a, alu_src_b, ula_operation, pc_source,
    //  instr_done, illegal_op}
    function automatic logic [17:0] f_pack(
        input logic pcw, input logic br, input logic iord, input logic mr,
        input logic mw, input logic irw, input logic m2r, input logic rdst,
        input logic rw, input logic asa, input logic [1:0] asb,
        input logic [1:0] ula, input logic [1:0] pcs, input logic done,
        input logic ill);
        return {pcw, br, iord, mr, mw, irw, m2r, rdst, rw, asa, asb, ula, pcs, done, ill};
    endfunction

    localparam logic [17:0] c_E_RST     = f_pack(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0);
    localparam logic [17:0] c_E_FETCH   = f_pack(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0,0);
    localparam logic [17:0] c_E_DEC     = f_pack(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0);
    localparam logic [17:0] c_E_DEC_ILL = f_pack(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,1);
    localparam logic [17:0] c_E_MADDR   = f_pack(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0);
    localparam logic [17:0] c_E_MREAD   = f_pack(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0);
    localparam logic [17:0] c_E_MWB     = f_pack(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,1,0);
    localparam logic [17:0] c_E_MWR_S   = f_pack(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0);
    localparam logic [17:0] c_E_MWR_R   = f_pack(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,1,0);
    localparam logic [17:0] c_E_EXEC    = f_pack(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0);
    localparam logic [17:0] c_E_RWB     = f_pack(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,1,0);
    localparam logic [17:0] c_E_BR      = f_pack(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,1,0);
    localparam logic [17:0] c_E_JMP     = f_pack(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1,0);
    localparam logic [17:0] c_E_AEX     = f_pack(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0);
    localparam logic [17:0] c_E_AWB     = f_pack(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,1,0);

    localparam logic [5:0] c_R   = 6'b000000;
    localparam logic [5:0] c_LW  = 6'b100011;
    localparam logic [5:0] c_SW  = 6'b101011;
    localparam logic [5:0] c_BEQ = 6'b000100;
    localparam logic [5:0] c_J   = 6'b000010;
    localparam logic [5:0] c_ADI = 6'b001000;
    localparam logic [5:0] c_BAD = 6'b111111;

    typedef struct {
        logic        rst_n;
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [17:0] ex;
    } vec_t;

    logic        r_clk = 1'b0;
    logic        r_rst_a = 1'b0, r_rst_b = 1'b0;
    logic [5:0]  r_op_a = '0, r_op_b = '0;
    logic        r_rdy_a = 1'b0, r_rdy_b = 1'b0;
    logic [17:0] w_out_a, w_out_b;
    logic [3:0]  w_st_a, w_st_b;
    int          n_vec = 0;
    int          n_err = 0;
    vec_t        vecs[$];

    always #5 r_clk = ~r_clk;

    mips_control_fsm #(.MEM_WAIT_EN(1), .STATE_W(4)) u_dut_a (
        .clock(r_clk), .reset(r_rst_a), .opcode(r_op_a), .mem_ready(r_rdy_a),
        .pc_write(w_out_a[17]), .branch(w_out_a[16]), .i_or_d(w_out_a[15]),
        .mem_read(w_out_a[14]), .mem_write(w_out_a[13]), .ir_write(w_out_a[12]),
        .mem_to_reg(w_out_a[11]), .reg_dst(w_out_a[10]), .reg_write(w_out_a[9]),
        .alu_src_a(w_out_a[8]), .alu_src_b(w_out_a[7:6]), .ula_operation(w_out_a[5:4]),
        .pc_source(w_out_a[3:2]), .instr_done(w_out_a[1]), .illegal_op(w_out_a[0]),
        .state(w_st_a)
    );

    mips_control_fsm #(.MEM_WAIT_EN(0), .STATE_W(4)) u_dut_b (
        .clock(r_clk), .reset(r_rst_b), .opcode(r_op_b), .mem_ready(r_rdy_b),
        .pc_write(w_out_b[17]), .branch(w_out_b[16]), .i_or_d(w_out_b[15]),
        .mem_read(w_out_b[14]), .mem_write(w_out_b[13]), .ir_write(w_out_b[12]),
        .mem_to_reg(w_out_b[11]), .reg_dst(w_out_b[10]), .reg_write(w_out_b[9]),
        .alu_src_a(w_out_b[8]), .alu_src_b(w_out_b[7:6]), .ula_operation(w_out_b[5:4]),
        .pc_source(w_out_b[3:2]), .instr_done(w_out_b[1]), .illegal_op(w_out_b[0]),
        .state(w_st_b)
    );

    task automatic add(input logic rst_n, input logic [5:0] op, input logic rdy,
                       input logic [3:0] st, input logic [17:0] ex);
        vec_t v;
        v.rst_n = rst_n; v.op = op; v.rdy = rdy; v.st = st; v.ex = ex;
        vecs.push_back(v);
    endtask

    // Drive on the falling edge, check 1 time unit later, well before the next rising edge
    task automatic apply(input int dut, input vec_t v, input string tag, input int idx);
        logic [3:0]  act_st;
        logic [17:0] act_out;
        @(negedge r_clk);
        if (dut == 0) begin
            r_rst_a = v.rst_n; r_op_a = v.op; r_rdy_a = v.rdy;
        end else begin
            r_rst_b = v.rst_n; r_op_b = v.op; r_rdy_b = v.rdy;
        end
        #1;
        act_st  = (dut == 0) ? w_st_a  : w_st_b;
        act_out = (dut == 0) ? w_out_a : w_out_b;
        n_vec++;
        if (act_st !== v.st || act_out !== v.ex) begin
            n_err++;
            $display("FAIL %s[%0d]: state=%0d outputs=%b, expected state=%0d outputs=%b",
                     tag, idx, act_st, act_out, v.st, v.ex);
        end
    endtask

    initial begin
        // Reset with mem_ready high: writes must stay masked
        add(0, c_R,   1, 4'd0,  c_E_RST);
        // lw, no stalls: 0,1,2,3,4
        add(1, c_LW,  1, 4'd0,  c_E_FETCH);
        add(1, c_LW,  1, 4'd1,  c_E_DEC);
        add(1, c_LW,  1, 4'd2,  c_E_MADDR);
        add(1, c_LW,  1, 4'd3,  c_E_MREAD);
        add(1, c_LW,  1, 4'd4,  c_E_MWB);
        // sw with three wait cycles in MEM_WRITE
        add(1, c_SW,  1, 4'd0,  c_E_FETCH);
        add(1, c_SW,  1, 4'd1,  c_E_DEC);
        add(1, c_SW,  1, 4'd2,  c_E_MADDR);
        add(1, c_SW,  0, 4'd5,  c_E_MWR_S);
        add(1, c_SW,  0, 4'd5,  c_E_MWR_S);
        add(1, c_SW,  0, 4'd5,  c_E_MWR_S);
        add(1, c_SW,  1, 4'd5,  c_E_MWR_R);
        // beq
        add(1, c_BEQ, 1, 4'd0,  c_E_FETCH);
        add(1, c_BEQ, 1, 4'd1,  c_E_DEC);
        add(1, c_BEQ, 1, 4'd8,  c_E_BR);
        // R-type then j back to back
        add(1, c_R,   1, 4'd0,  c_E_FETCH);
        add(1, c_R,   1, 4'd1,  c_E_DEC);
        add(1, c_R,   1, 4'd6,  c_E_EXEC);
        add(1, c_R,   1, 4'd7,  c_E_RWB);
        add(1, c_J,   1, 4'd0,  c_E_FETCH);
        add(1, c_J,   1, 4'd1,  c_E_DEC);
        add(1, c_J,   1, 4'd9,  c_E_JMP);
        // addi
        add(1, c_ADI, 1, 4'd0,  c_E_FETCH);
        add(1, c_ADI, 1, 4'd1,  c_E_DEC);
        add(1, c_ADI, 1, 4'd10, c_E_AEX);
        add(1, c_ADI, 1, 4'd11, c_E_AWB);
        // Fetch stall, then an illegal opcode
        add(1, c_BAD, 0, 4'd0,  c_E_RST);
        add(1, c_BAD, 1, 4'd0,  c_E_FETCH);
        add(1, c_BAD, 1, 4'd1,  c_E_DEC_ILL);
        // lw with one wait cycle in MEM_READ
        add(1, c_LW,  1, 4'd0,  c_E_FETCH);
        add(1, c_LW,  1, 4'd1,  c_E_DEC);
        add(1, c_LW,  1, 4'd2,  c_E_MADDR);
        add(1, c_LW,  0, 4'd3,  c_E_MREAD);
        add(1, c_LW,  1, 4'd3,  c_E_MREAD);
        add(1, c_LW,  1, 4'd4,  c_E_MWB);
        // Reset asserted mid-EXECUTE takes effect without a clock edge
        add(1, c_R,   1, 4'd0,  c_E_FETCH);
        add(1, c_R,   1, 4'd1,  c_E_DEC);
        add(1, c_R,   1, 4'd6,  c_E_EXEC);
        add(0, c_R,   1, 4'd0,  c_E_RST);
        add(1, c_R,   1, 4'd0,  c_E_FETCH);
        add(1, c_R,   1, 4'd1,  c_E_DEC);

        for (int i = 0; i < vecs.size(); i++) apply(0, vecs[i], "wait_en", i);

        // MEM_WAIT_EN=0 with mem_ready stuck low: memory states never stall
        vecs.delete();
        add(0, c_BAD, 0, 4'd0, c_E_RST);
        add(1, c_BAD, 0, 4'd0, c_E_FETCH);
        add(1, c_BAD, 0, 4'd1, c_E_DEC_ILL);
        add(1, c_SW,  0, 4'd0, c_E_FETCH);
        add(1, c_SW,  0, 4'd1, c_E_DEC);
        add(1, c_SW,  0, 4'd2, c_E_MADDR);
        add(1, c_SW,  0, 4'd5, c_E_MWR_R);
        add(1, c_LW,  0, 4'd0, c_E_FETCH);
        add(1, c_LW,  0, 4'd1, c_E_DEC);
        add(1, c_LW,  0, 4'd2, c_E_MADDR);
        add(1, c_LW,  0, 4'd3, c_E_MREAD);
        add(1, c_LW,  0, 4'd4, c_E_MWB);
        add(1, c_LW,  0, 4'd0, c_E_FETCH);

        for (int i = 0; i < vecs.size(); i++) apply(1, vecs[i], "no_wait", i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
